// File: rtl/coin_pkg.sv
// Shared types, constants and helpers for the coin slot scheduler.
// Optional respawn logic in coin_manager is enabled by defining COIN_RESPAWN_EN.
package coin_pkg;

  typedef logic [10:0] coord_t;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StRespawn,
    StDone
  } state_e;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  // Right-shift Galois taps for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LfsrTaps = 16'hB400;

  localparam int unsigned CoinX0    = 100;
  localparam int unsigned CoinXStep = 100;
  localparam int unsigned CoinY0    = 240;

  localparam int unsigned SpawnXOff = 64;
  localparam int unsigned SpawnYOff = 48;

  function automatic coord_t reset_x(input int unsigned slot);
    return coord_t'(CoinX0 + CoinXStep * slot);
  endfunction

  function automatic coord_t reset_y();
    return coord_t'(CoinY0);
  endfunction

  function automatic coord_t spawn_x(input logic [15:0] lfsr);
    return coord_t'(SpawnXOff) + {2'b00, lfsr[8:0]};
  endfunction

  function automatic coord_t spawn_y(input logic [15:0] lfsr);
    return coord_t'(SpawnYOff) + {3'b000, lfsr[15:8]} + {4'b0000, lfsr[15:9]};
  endfunction

  // Strict box overlap on 12-bit values so neither the sums nor the differences wrap.
  function automatic logic coin_overlap(input coord_t      car_x,
                                        input coord_t      car_y,
                                        input coord_t      car_size,
                                        input coord_t      cx,
                                        input coord_t      cy,
                                        input logic [11:0] half);
    logic [11:0] x0, x1, y0, y1, cxw, cyw;
    x0  = {1'b0, car_x};
    y0  = {1'b0, car_y};
    x1  = x0 + {1'b0, car_size};
    y1  = y0 + {1'b0, car_size};
    cxw = {1'b0, cx};
    cyw = {1'b0, cy};
    return (x0 < cxw + half) && (x1 > cxw - half) && (y0 < cyw + half) && (y1 > cyw - half);
  endfunction

endpackage

// File: rtl/coin_lfsr.sv
// Free-running 16-bit Galois LFSR that supplies coin respawn positions.
module coin_lfsr
  import coin_pkg::*;
(
  input  logic        vga_clk,
  input  logic        Reset,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/coin_manager.sv
// Frame-sequenced coin slot scheduler: one shared car/coin comparator walks the slots each frame.
// Define COIN_RESPAWN_EN to build the respawn counters and LFSR; otherwise collected slots stay empty.
module coin_manager
  import coin_pkg::*;
#(
  parameter int unsigned NUM_COINS      = 4,
  parameter int unsigned COIN_HALF      = 2,
  parameter int unsigned RESPAWN_FRAMES = 120,
  parameter int unsigned SCORE_W        = 8
) (
  input  logic                   vga_clk,
  input  logic                   Reset,
  input  logic                   frame_start,
  input  logic [10:0]            Car_X_Pos,
  input  logic [10:0]            Car_Y_Pos,
  input  logic [10:0]            Car_Size,
  output logic [11*NUM_COINS-1:0] coin_x_flat,
  output logic [11*NUM_COINS-1:0] coin_y_flat,
  output logic [NUM_COINS-1:0]   coin_active,
  output logic                   collect_coin,
  output logic [SCORE_W-1:0]     score,
  output logic                   busy,
  output logic                   frame_miss
);

  localparam int unsigned        IdxW     = $clog2(NUM_COINS);
  localparam logic [IdxW-1:0]    LastIdx  = IdxW'(NUM_COINS - 1);
  localparam logic [SCORE_W-1:0] ScoreMax = '1;

  state_e                 state_q;
  logic [IdxW-1:0]        idx_q;
  coord_t                 snap_x_q, snap_y_q, snap_size_q;
  coord_t                 coin_x_q [NUM_COINS];
  coord_t                 coin_y_q [NUM_COINS];
  logic [NUM_COINS-1:0]   active_q;
  logic                   collect_q, busy_q, miss_q;
  logic [SCORE_W-1:0]     score_q;
  logic                   hit;

  assign hit = active_q[idx_q] &&
               coin_overlap(snap_x_q, snap_y_q, snap_size_q, coin_x_q[idx_q], coin_y_q[idx_q],
                            12'(COIN_HALF));

`ifdef COIN_RESPAWN_EN
  localparam int unsigned CntW = (RESPAWN_FRAMES > 0) ? $clog2(RESPAWN_FRAMES + 1) : 1;
  typedef logic [CntW-1:0] cnt_t;

  logic [15:0]          lfsr;
  cnt_t                 cnt_q [NUM_COINS];
  // Slots retired during the current pass; they wait full frames before counting down.
  logic [NUM_COINS-1:0] hit_q;
  logic [NUM_COINS-1:0] ready;
  logic [NUM_COINS-1:0] spawn_sel;

  coin_lfsr u_lfsr (
    .vga_clk (vga_clk),
    .Reset   (Reset),
    .lfsr    (lfsr)
  );

  always_comb begin
    ready = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      ready[i] = !active_q[i] && (cnt_q[i] == '0) && !hit_q[i];
    end
    // Isolate the lowest set bit: at most one respawn per frame.
    spawn_sel = ready & (~ready + NUM_COINS'(1));
  end
`else
  logic unused_respawn_frames;
  assign unused_respawn_frames = ^RESPAWN_FRAMES;
`endif

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      snap_x_q    <= '0;
      snap_y_q    <= '0;
      snap_size_q <= '0;
      active_q    <= '1;
      collect_q   <= 1'b0;
      busy_q      <= 1'b0;
      miss_q      <= 1'b0;
      score_q     <= '0;
      for (int i = 0; i < NUM_COINS; i++) begin
        coin_x_q[i] <= reset_x(i);
        coin_y_q[i] <= reset_y();
      end
`ifdef COIN_RESPAWN_EN
      hit_q <= '0;
      for (int i = 0; i < NUM_COINS; i++) begin
        cnt_q[i] <= '0;
      end
`endif
    end else begin
      collect_q <= 1'b0;
      miss_q    <= frame_start && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            snap_x_q    <= Car_X_Pos;
            snap_y_q    <= Car_Y_Pos;
            snap_size_q <= Car_Size;
            idx_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= StScan;
`ifdef COIN_RESPAWN_EN
            hit_q       <= '0;
`endif
          end
        end
        StScan: begin
          if (hit) begin
            active_q[idx_q] <= 1'b0;
            collect_q       <= 1'b1;
            if (score_q != ScoreMax) begin
              score_q <= score_q + 1'b1;
            end
`ifdef COIN_RESPAWN_EN
            cnt_q[idx_q] <= CntW'(RESPAWN_FRAMES);
            hit_q[idx_q] <= 1'b1;
`endif
          end
          if (idx_q == LastIdx) begin
            state_q <= StRespawn;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StRespawn: begin
`ifdef COIN_RESPAWN_EN
          for (int i = 0; i < NUM_COINS; i++) begin
            if (!active_q[i] && (cnt_q[i] != '0) && !hit_q[i]) begin
              cnt_q[i] <= cnt_q[i] - 1'b1;
            end
            if (spawn_sel[i]) begin
              active_q[i] <= 1'b1;
              coin_x_q[i] <= spawn_x(lfsr);
              coin_y_q[i] <= spawn_y(lfsr);
            end
          end
`endif
          state_q <= StDone;
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    coin_x_flat = '0;
    coin_y_flat = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      coin_x_flat[11*i +: 11] = coin_x_q[i];
      coin_y_flat[11*i +: 11] = coin_y_q[i];
    end
  end

  assign coin_active  = active_q;
  assign collect_coin = collect_q;
  assign score        = score_q;
  assign busy         = busy_q;
  assign frame_miss   = miss_q;

endmodule

// File: tb/tb_coin_manager.sv
// Directed bench for coin_manager: a table of frame passes plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_coin_manager;

  localparam int unsigned N = 4;

  logic            clk = 1'b0;
  logic            rst, fs;
  logic [10:0]     car_x, car_y, car_s;
  logic [11*N-1:0] cx_flat, cy_flat, sx_flat, sy_flat;
  logic [N-1:0]    act, s_act;
  logic            coll, s_coll, busy, s_busy, miss, s_miss;
  logic [7:0]      score;
  logic [1:0]      s_score;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  coin_manager #(.NUM_COINS(N)) u_dut (
    .vga_clk      (clk),
    .Reset        (rst),
    .frame_start  (fs),
    .Car_X_Pos    (car_x),
    .Car_Y_Pos    (car_y),
    .Car_Size     (car_s),
    .coin_x_flat  (cx_flat),
    .coin_y_flat  (cy_flat),
    .coin_active  (act),
    .collect_coin (coll),
    .score        (score),
    .busy         (busy),
    .frame_miss   (miss)
  );

  // Narrow score counter so saturation is reachable with four slots.
  coin_manager #(.NUM_COINS(N), .SCORE_W(2)) u_sat (
    .vga_clk      (clk),
    .Reset        (rst),
    .frame_start  (fs),
    .Car_X_Pos    (car_x),
    .Car_Y_Pos    (car_y),
    .Car_Size     (car_s),
    .coin_x_flat  (sx_flat),
    .coin_y_flat  (sy_flat),
    .coin_active  (s_act),
    .collect_coin (s_coll),
    .score        (s_score),
    .busy         (s_busy),
    .frame_miss   (s_miss)
  );

  typedef struct {
    bit          do_rst;
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] s;
    logic [3:0]  hits;
    logic [3:0]  active;
    int unsigned score;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [11*N-1:0] exp_rst_x();
    logic [11*N-1:0] v;
    v = '0;
    for (int i = 0; i < int'(N); i++) v[11*i +: 11] = 11'(100 + 100 * i);
    return v;
  endfunction

  function automatic logic [11*N-1:0] exp_rst_y();
    logic [11*N-1:0] v;
    v = '0;
    for (int i = 0; i < int'(N); i++) v[11*i +: 11] = 11'd240;
    return v;
  endfunction

  // One frame pass; car inputs are scrambled after the snapshot edge to prove they are ignored.
  task automatic do_pass(input logic [10:0] x, input logic [10:0] y, input logic [10:0] s,
                         output logic [7:0] hseq, output logic [7:0] shseq, output int bcnt,
                         output logic bfirst, output logic anymiss);
    hseq    = '0;
    shseq   = '0;
    bcnt    = 0;
    anymiss = 1'b0;
    car_x   = x;
    car_y   = y;
    car_s   = s;
    fs      = 1'b1;
    tick();
    fs      = 1'b0;
    car_x   = 11'd0;
    car_y   = 11'd0;
    car_s   = 11'd2047;
    bfirst  = busy;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      hseq[i]  = coll;
      shseq[i] = s_coll;
      if (busy) bcnt++;
      if (miss) anymiss = 1'b1;
    end
  endtask

  initial begin
    logic [7:0]  hseq, shseq;
    int          bcnt;
    logic        bfirst, anymiss;
    int unsigned sat_exp;
    logic [10:0] rx, ry;

    vecs[0]  = '{1'b1, 11'd50,  11'd50,  11'd20,   4'b0000, 4'b1111, 0};
    vecs[1]  = '{1'b0, 11'd190, 11'd230, 11'd20,   4'b0010, 4'b1101, 1};
    vecs[2]  = '{1'b1, 11'd95,  11'd230, 11'd120,  4'b0011, 4'b1100, 2};
    vecs[3]  = '{1'b0, 11'd290, 11'd230, 11'd120,  4'b1100, 4'b0000, 4};
    vecs[4]  = '{1'b0, 11'd290, 11'd230, 11'd120,  4'b0000, 4'b0000, 4};
    vecs[5]  = '{1'b1, 11'd0,   11'd0,   11'd2047, 4'b1111, 4'b0000, 4};
    vecs[6]  = '{1'b1, 11'd102, 11'd230, 11'd20,   4'b0000, 4'b1111, 0};
    vecs[7]  = '{1'b0, 11'd78,  11'd230, 11'd20,   4'b0000, 4'b1111, 0};
    vecs[8]  = '{1'b0, 11'd95,  11'd242, 11'd20,   4'b0000, 4'b1111, 0};
    vecs[9]  = '{1'b0, 11'd95,  11'd218, 11'd20,   4'b0000, 4'b1111, 0};
    vecs[10] = '{1'b0, 11'd101, 11'd219, 11'd20,   4'b0001, 4'b1110, 1};

    rst   = 1'b0;
    fs    = 1'b0;
    car_x = 11'd0;
    car_y = 11'd0;
    car_s = 11'd0;

    // Reset state
    do_reset();
    check("rst_x", 64'(cx_flat), 64'(exp_rst_x()));
    check("rst_y", 64'(cy_flat), 64'(exp_rst_y()));
    check("rst_active", 64'(act), 64'(4'b1111));
    check("rst_score", 64'(score), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_collect", 64'(coll), 64'(0));
    check("rst_miss", 64'(miss), 64'(0));

    // Table of frame passes
    for (int v = 0; v < 11; v++) begin
      if (vecs[v].do_rst) do_reset();
      do_pass(vecs[v].x, vecs[v].y, vecs[v].s, hseq, shseq, bcnt, bfirst, anymiss);
      sat_exp = (vecs[v].score > 3) ? 3 : vecs[v].score;
      check($sformatf("v%0d_collect_seq", v), 64'(hseq), 64'({3'b000, vecs[v].hits, 1'b0}));
      check($sformatf("v%0d_sat_collect_seq", v), 64'(shseq), 64'({3'b000, vecs[v].hits, 1'b0}));
      check($sformatf("v%0d_busy_len", v), 64'(bcnt), 64'(6));
      check($sformatf("v%0d_busy_rise", v), 64'(bfirst), 64'(1));
      check($sformatf("v%0d_active", v), 64'(act), 64'(vecs[v].active));
      check($sformatf("v%0d_score", v), 64'(score), 64'(vecs[v].score));
      check($sformatf("v%0d_sat_score", v), 64'(s_score), 64'(sat_exp));
      check($sformatf("v%0d_no_miss", v), 64'(anymiss), 64'(0));
    end

    // frame_start two cycles into a pass
    do_reset();
    car_x = 11'd50;
    car_y = 11'd50;
    car_s = 11'd20;
    bcnt  = 0;
    anymiss = 1'b0;
    fs = 1'b1;
    tick();
    fs = 1'b0;
    if (busy) bcnt++;
    if (coll) anymiss = 1'b1;
    tick();
    if (busy) bcnt++;
    if (coll) anymiss = 1'b1;
    fs = 1'b1;
    tick();
    fs = 1'b0;
    if (busy) bcnt++;
    if (coll) anymiss = 1'b1;
    check("miss_pulse", 64'(miss), 64'(1));
    tick();
    if (busy) bcnt++;
    if (coll) anymiss = 1'b1;
    check("miss_one_cycle", 64'(miss), 64'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy) bcnt++;
      if (coll) anymiss = 1'b1;
    end
    check("miss_busy_len", 64'(bcnt), 64'(6));
    check("miss_no_collect", 64'(anymiss), 64'(0));
    check("miss_score", 64'(score), 64'(0));

    // Reset asserted mid-SCAN
    do_reset();
    do_pass(11'd190, 11'd230, 11'd20, hseq, shseq, bcnt, bfirst, anymiss);
    check("mid_pre_score", 64'(score), 64'(1));
    car_x = 11'd0;
    car_y = 11'd0;
    car_s = 11'd2047;
    fs = 1'b1;
    tick();
    fs = 1'b0;
    tick();
    check("mid_slot0_collect", 64'(coll), 64'(1));
    check("mid_slot0_score", 64'(score), 64'(2));
    rst = 1'b1;
    tick();
    check("mid_rst_score", 64'(score), 64'(0));
    check("mid_rst_active", 64'(act), 64'(4'b1111));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_collect", 64'(coll), 64'(0));
    check("mid_rst_x", 64'(cx_flat), 64'(exp_rst_x()));
    check("mid_rst_y", 64'(cy_flat), 64'(exp_rst_y()));
    rst = 1'b0;
    tick();
    tick();
    check("mid_post_busy", 64'(busy), 64'(0));
    check("mid_post_score", 64'(score), 64'(0));

    // Respawn timing for slot 1
    do_reset();
    do_pass(11'd190, 11'd230, 11'd20, hseq, shseq, bcnt, bfirst, anymiss);
    check("resp_collected", 64'(act), 64'(4'b1101));
    for (int f = 1; f <= 121; f++) begin
      do_pass(11'd50, 11'd50, 11'd20, hseq, shseq, bcnt, bfirst, anymiss);
      if (f == 120) check("resp_f120_empty", 64'(act), 64'(4'b1101));
    end
    rx = cx_flat[11 +: 11];
    ry = cy_flat[11 +: 11];
`ifdef COIN_RESPAWN_EN
    check("resp_f121_active", 64'(act), 64'(4'b1111));
    check("resp_x_range", 64'((rx >= 11'd64) && (rx <= 11'd575)), 64'(1));
    check("resp_y_range", 64'((ry >= 11'd48) && (ry <= 11'd430)), 64'(1));
`else
    check("resp_f121_still_empty", 64'(act), 64'(4'b1101));
    check("resp_x_kept", 64'(rx), 64'(200));
    check("resp_y_kept", 64'(ry), 64'(240));
`endif
    check("resp_score", 64'(score), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/coin_manager.md
# coin_manager

Frame-synchronous scheduler that owns the pool of coin slots on the track. Once per frame it checks each active coin against the car's bounding box, retires collected coins, updates the score and respawns coins after a timeout. It sits between the car motion logic (car position and size) and the renderer (coin positions and active mask), and replaces per-coin free-running collision logic with one shared, sequenced comparator.

## Interface
Parameters:
- NUM_COINS, 4: number of coin slots (2..8).
- COIN_HALF, 2: coin half-width in pixels; the coin box is center ± COIN_HALF.
- RESPAWN_FRAMES, 120: frames a collected slot stays empty before it respawns.
- SCORE_W, 8: width of the score counter.

Ports (one clock; reset is synchronous and active-high):
- vga_clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- Car_X_Pos  in  11  car top-left x
- Car_Y_Pos  in  11  car top-left y
- Car_Size  in  11  car box edge length
- coin_x_flat  out  11*NUM_COINS  coin center x; slot i at bits [11i+10:11i]
- coin_y_flat  out  11*NUM_COINS  coin center y; same packing
- coin_active  out  NUM_COINS  1 = slot visible and collectable
- collect_coin  out  1  one-cycle pulse per coin collected
- score  out  SCORE_W  coins collected since reset, saturating
- busy  out  1  high while a frame pass is in progress
- frame_miss  out  1  one-cycle pulse when frame_start arrives while busy

## Operation
- Reset values:
  - Slot i center = (100+100·i, 240); all slots active.
  - All respawn counters 0.
  - score = 0; collect_coin, busy and frame_miss = 0.
  - FSM in IDLE; LFSR = 16'hACE1.
- FSM states: IDLE, SCAN, RESPAWN, DONE.
  - IDLE: on frame_start, latch Car_X_Pos, Car_Y_Pos and Car_Size into a snapshot, clear idx, assert busy, go to SCAN.
  - SCAN: one slot per cycle, idx = 0..NUM_COINS-1.
    - If the slot is active and overlaps the car, clear active, load the slot counter with RESPAWN_FRAMES, pulse collect_coin and increment score.
    - Go to RESPAWN after idx = NUM_COINS-1.
  - RESPAWN:
    - Every inactive slot with a nonzero counter decrements.
    - The lowest-index inactive slot whose counter is already 0 is reloaded from the LFSR and set active. At most one respawn per frame.
    - Go to DONE.
  - DONE: deassert busy, go to IDLE.
- Overlap test uses the snapshot and strict comparisons on 12-bit intermediates, so there is no wrap. All four conditions must hold:
  - car_x < cx+COIN_HALF
  - car_x+Car_Size > cx−COIN_HALF
  - car_y < cy+COIN_HALF
  - car_y+Car_Size > cy−COIN_HALF
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, advances every cycle.
  - Spawn x = 64 + lfsr[8:0] (range 64..575).
  - Spawn y = 48 + lfsr[15:8] + lfsr[15:9] (range 48..430).
- Score increments by 1 per collected coin and holds at 2^SCORE_W−1.
- Multiple hits in one pass pulse collect_coin on separate consecutive SCAN cycles.
- Coin outputs are registered and change only in SCAN or RESPAWN cycles. Inactive slots keep their last position.

## Timing
- Frame pass length: NUM_COINS+2 cycles.
  - busy rises on the cycle after frame_start.
  - busy falls after the DONE cycle.
- collect_coin and the coin_active clear for slot k are both visible on the cycle after SCAN idx = k.
- frame_start while busy: the pulse is ignored, frame_miss pulses one cycle, and the current pass completes unchanged.
- Reset asserted mid-pass: all state returns to reset values on the next edge. No partial score is kept.
- Car inputs that change during a pass have no effect; only the snapshot is used.

## Configuration
- COIN_RESPAWN_EN:
  - Defined: RESPAWN behaves as described.
  - Undefined: RESPAWN is a pass-through cycle. Collected slots stay inactive until Reset, and the LFSR and counters are removed.
- Pass length is identical in both builds.

## Structure
- Package coin_pkg holds:
  - coord_t (logic [10:0])
  - the state enum
  - LFSR seed and tap mask
  - reset coin position constants and spawn offsets (64, 48)
- One sub-module, coin_lfsr, with ports vga_clk, Reset, lfsr[15:0].

## Test plan
- Reset, then frame_start with the car at (50,50) and size 20 (no overlap) → no collect_coin, score 0, busy high for exactly 6 cycles (NUM_COINS=4).
- Car at (190,230), size 20 (covers slot 1 at 200,240) → collect_coin pulses once on the cycle after idx=1, coin_active=4'b1101, score 1.
- Car box covers slots 0 and 1 (e.g. at (95,230), size 120) → two collect_coin pulses on consecutive cycles, score 2.
- Collect slot 1, then 121 further frames → slot 1 reactivates on frame 121, spawn x in 64..575 and y in 48..430. With COIN_RESPAWN_EN undefined, it never reactivates.
- frame_start pulsed 2 cycles after a previous frame_start → frame_miss pulses and the pass length is unchanged. Reset asserted in SCAN → all outputs return to reset values next cycle.
- Force score to 255 (SCORE_W=8) via repeated collections → further hits still pulse collect_coin, and score stays 255.
